// File: rtl/boa_sim_mem_arb.sv
// Shared word-wide simulation memory with round-robin arbitration over NPORTS bus masters.
// Optional macro BOA_SIM_MEM_FAULT_EN turns out-of-range requests into fault completions.
module boa_sim_mem_arb #(
   parameter int    NPORTS   = 2,
   parameter int    DEPTH    = 16384,
   parameter int    LATENCY  = 0,
   parameter string INIT_HEX = ""
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NPORTS-1:0]      re,
   input  logic [NPORTS*4-1:0]    we,
   input  logic [NPORTS*32-1:0]   addr,
   input  logic [NPORTS*32-1:0]   wdata,
   output logic [NPORTS*32-1:0]   rdata,
   output logic [NPORTS-1:0]      ready,
   output logic [NPORTS-1:0]      fault
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   state_t          state_next;
   logic [31:0]     mem [DEPTH];
   logic [NPORTS-1:0] req;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gnt;
   logic [PW-1:0]   pick;
   logic            found;
   logic [AW-1:0]   idx_r;
   logic [31:0]     wdata_r;
   logic [3:0]      we_r;
   logic [3:0]      cnt;
   logic            commit;
   logic            unused_bits;
`ifdef BOA_SIM_MEM_FAULT_EN
   logic            oor_r;
   logic [31:0]     fault_addr_r;
`endif

   // Byte-offset and out-of-window address bits are deliberately ignored
   assign unused_bits = ^addr;

   // Per-port request decode
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         req[p] = re[p] | (|we[4*p +: 4]);
      end
   end

   // First requester at or after rr_ptr, scanning upward with wrap
   always_comb begin
      int j;
      pick  = rr_ptr;
      found = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NPORTS) j = j - NPORTS;
         if (!found && req[j]) begin
            pick  = PW'(j);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = WAIT; else state_next = IDLE;
         WAIT:    if (cnt == 4'd0) state_next = RESP; else state_next = WAIT;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Grant capture, wait count, pointer advance and registered responses
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr  <= '0;
         gnt     <= '0;
         idx_r   <= '0;
         wdata_r <= 32'd0;
         we_r    <= 4'd0;
         cnt     <= 4'd0;
         ready   <= '0;
         fault   <= '0;
         rdata   <= '0;
`ifdef BOA_SIM_MEM_FAULT_EN
         oor_r        <= 1'b0;
         fault_addr_r <= 32'd0;
`endif
      end else begin
         ready <= '0;
         fault <= '0;
         rdata <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt     <= pick;
                  idx_r   <= addr[32*int'(pick) + 2 +: AW];
                  wdata_r <= wdata[32*int'(pick) +: 32];
                  we_r    <= we[4*int'(pick) +: 4];
                  cnt     <= 4'(LATENCY);
`ifdef BOA_SIM_MEM_FAULT_EN
                  oor_r        <= (addr[32*int'(pick) +: 32] >> (AW + 2)) != 32'd0;
                  fault_addr_r <= addr[32*int'(pick) +: 32];
`endif
               end
            end
            WAIT: begin
               // Response registers load here so ready is high exactly during RESP
               if (cnt == 4'd0) begin
                  ready[gnt] <= 1'b1;
`ifdef BOA_SIM_MEM_FAULT_EN
                  if (oor_r) begin
                     fault[gnt]                  <= 1'b1;
                     rdata[32*int'(gnt) +: 32]   <= 32'hDEAD_BEEF;
                     $display("boa_sim_mem_arb: port %0d out-of-range address %h", gnt, fault_addr_r);
                  end else begin
                     rdata[32*int'(gnt) +: 32]   <= mem[idx_r];
                  end
`else
                  rdata[32*int'(gnt) +: 32] <= mem[idx_r];
`endif
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: rr_ptr <= (int'(gnt) == NPORTS - 1) ? '0 : gnt + PW'(1);
            default: rr_ptr <= rr_ptr;
         endcase
      end
   end

`ifdef BOA_SIM_MEM_FAULT_EN
   assign commit = rst && (state == RESP) && !oor_r;
`else
   assign commit = rst && (state == RESP);
`endif

   // Byte-lane write commit as the response cycle closes; read data was taken earlier
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (we_r[b]) mem[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
         end
      end
   end

endmodule
